// File: rtl/whistle_pkg.sv
// Shared definitions for the whistle audio output stage: PWM geometry and the
// amplifier power-state encoding.
package whistle_pkg;

    localparam int PWM_BITS  = 8;
    localparam int FRAME_LEN = 256;

    typedef logic [1:0] state_t;

    localparam state_t ST_OFF  = 2'd0;
    localparam state_t ST_WAKE = 2'd1;
    localparam state_t ST_PLAY = 2'd2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/whistle_pwm_out_pwm_core.sv
// Free-running PWM frame counter with a duty register latched once per frame;
// exports the frame-boundary strobe used to pace the power FSM.
module pwm_core
    import whistle_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] duty_in,
    input  logic                load_zero,
    output logic                pwm_out,
    output logic                boundary
);

    logic [PWM_BITS-1:0] frm_cnt;
    logic [PWM_BITS-1:0] duty;

    assign boundary = (frm_cnt == PWM_BITS'(FRAME_LEN - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; pwm_out therefore compares against the duty of the frame
    // just ending at the boundary edge, which keeps offset 0 low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            frm_cnt <= frm_cnt + 1'b1;
            if (boundary) begin
                duty <= load_zero ? '0 : duty_in;
            end
            pwm_out <= (frm_cnt < duty);
        end
    end

endmodule

// File: rtl/whistle_pwm_out.sv
// Whistle audio output: PWM of the gated sample stream plus an amplifier power
// FSM (OFF -> WAKE -> PLAY -> OFF) stepped only at PWM frame boundaries.
module whistle_pwm_out
    import whistle_pkg::*;
#(
    parameter int WAKE_FRAMES = 16,
    parameter int IDLE_FRAMES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] sig_in,
    output logic                pwm_out,
    output logic                amp_sd_n,
    output logic                playing
);

    localparam int FCTR_W = $clog2(max_int(WAKE_FRAMES, IDLE_FRAMES)) + 1;
    localparam logic [FCTR_W-1:0] WAKE_LAST = FCTR_W'(WAKE_FRAMES - 1);
    localparam logic [FCTR_W-1:0] IDLE_LAST = FCTR_W'(IDLE_FRAMES - 1);

    state_t              state, state_nxt;
    logic [FCTR_W-1:0]   fctr, fctr_nxt, fctr_inc;
    logic                amp_nxt, playing_nxt;
    logic                boundary;
    logic                sig_nz;

    assign sig_nz   = |sig_in;
    assign fctr_inc = (&fctr) ? fctr : fctr + 1'b1;

    pwm_core u_pwm_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .duty_in   (sig_in),
        .load_zero (state != ST_PLAY),
        .pwm_out   (pwm_out),
        .boundary  (boundary)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_OFF;
            fctr     <= '0;
            amp_sd_n <= 1'b0;
            playing  <= 1'b0;
        end else begin
            state    <= state_nxt;
            fctr     <= fctr_nxt;
            amp_sd_n <= amp_nxt;
            playing  <= playing_nxt;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a latch behind.
    always_comb begin
        state_nxt = state;
        fctr_nxt  = fctr;
        if (boundary) begin
            case (state)
                ST_OFF: begin
                    fctr_nxt = '0;
                    if (sig_nz) state_nxt = ST_WAKE;
                end
                ST_WAKE: begin
                    if (fctr == WAKE_LAST) begin
                        state_nxt = ST_PLAY;
                        fctr_nxt  = '0;
                    end else begin
                        fctr_nxt = fctr_inc;
                    end
                end
                ST_PLAY: begin
                    if (sig_nz) begin
                        fctr_nxt = '0;
                    end else if (fctr == IDLE_LAST) begin
                        state_nxt = ST_OFF;
                        fctr_nxt  = '0;
                    end else begin
                        fctr_nxt = fctr_inc;
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                    fctr_nxt  = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered alongside it, so
    // amp_sd_n and playing switch glitch-free on the boundary edge itself.
    always_comb begin
        amp_nxt     = (state_nxt != ST_OFF);
        playing_nxt = (state_nxt == ST_PLAY);
    end

endmodule

// File: tb/tb_whistle_pwm_out.sv
// Directed bench for whistle_pwm_out with short wake/idle windows; counts PWM
// high cycles per frame and checks the power FSM at exact boundary edges.
module tb_whistle_pwm_out;

    localparam int WAKE_FRAMES = 2;
    localparam int IDLE_FRAMES = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sig_in = 8'd0;
    logic       pwm_out;
    logic       amp_sd_n;
    logic       playing;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    whistle_pwm_out #(
        .WAKE_FRAMES (WAKE_FRAMES),
        .IDLE_FRAMES (IDLE_FRAMES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_in   (sig_in),
        .pwm_out  (pwm_out),
        .amp_sd_n (amp_sd_n),
        .playing  (playing)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Runs one full frame (256 edges) starting just after a boundary edge.
    task automatic check_frame(input string tag, input int exp_hi, input bit glitch);
        int   hi;
        int   first_hi;
        logic last;
        hi       = 0;
        first_hi = -1;
        last     = 1'bx;
        for (int i = 1; i <= 256; i++) begin
            @(posedge clk);
            #1;
            if (pwm_out === 1'b1) begin
                hi++;
                if (first_hi < 0) first_hi = i;
            end
            last = pwm_out;
            if (glitch && i == 60)  sig_in = 8'd200;
            if (glitch && i == 120) sig_in = 8'd50;
        end
        check({tag, "_high_cycles"}, hi, exp_hi);
        if (exp_hi > 0) check({tag, "_first_high"}, first_hi, 1);
        check({tag, "_offset0_low"}, {31'd0, last}, 32'd0);
    endtask

    initial begin
        int hi;

        // Reset state
        sig_in = 8'd128;
        rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pwm", {31'd0, pwm_out}, 0);
        check("rst_amp", {31'd0, amp_sd_n}, 0);
        check("rst_playing", {31'd0, playing}, 0);
        rst_n = 1'b1;

        // Wake: first boundary at cycle 255, amp up at 256, PLAY at 3rd boundary
        hi = 0;
        for (int i = 0; i < 255; i++) begin
            step(1);
            if (pwm_out === 1'b1) hi++;
        end
        check("wake_pwm_quiet", hi, 0);
        check("wake_amp_c255", {31'd0, amp_sd_n}, 0);
        step(1);
        check("wake_amp_c256", {31'd0, amp_sd_n}, 1);
        check("wake_playing_c256", {31'd0, playing}, 0);
        step(511);
        check("wake_playing_c767", {31'd0, playing}, 0);
        step(1);
        check("wake_playing_c768", {31'd0, playing}, 1);
        check_frame("wake_gap", 0, 1'b0);
        check_frame("d128_a", 128, 1'b0);

        // Duty extremes; sig_in changes mid-frame are only seen at the next boundary
        sig_in = 8'd255;
        check_frame("d128_b", 128, 1'b0);
        sig_in = 8'd1;
        check_frame("d255", 255, 1'b0);
        sig_in = 8'd50;
        check_frame("d1", 1, 1'b0);
        check_frame("glitch", 50, 1'b1);

        // Three zero boundaries then a non-zero sample keeps PLAY
        sig_in = 8'd0;
        check_frame("pre_idle", 50, 1'b0);
        check("idle_z1_playing", {31'd0, playing}, 1);
        check_frame("z1", 0, 1'b0);
        check_frame("z2", 0, 1'b0);
        check("idle_z3_playing", {31'd0, playing}, 1);
        sig_in = 8'd10;
        check_frame("z3", 0, 1'b0);
        check("rescue_playing", {31'd0, playing}, 1);
        check("rescue_amp", {31'd0, amp_sd_n}, 1);

        // Four zero boundaries shut the amplifier down
        sig_in = 8'd0;
        check_frame("d10", 10, 1'b0);
        check_frame("zz2", 0, 1'b0);
        check_frame("zz3", 0, 1'b0);
        check("shut_pre_playing", {31'd0, playing}, 1);
        step(255);
        check("shut_c255_amp", {31'd0, amp_sd_n}, 1);
        check("shut_c255_playing", {31'd0, playing}, 1);
        step(1);
        check("shut_amp", {31'd0, amp_sd_n}, 0);
        check("shut_playing", {31'd0, playing}, 0);
        check_frame("off", 0, 1'b0);
        check("off_amp", {31'd0, amp_sd_n}, 0);

        // Re-wake, then async reset mid-PLAY at offset 20 with duty 100
        sig_in = 8'd100;
        check_frame("rewake_off", 0, 1'b0);
        check("rewake_amp", {31'd0, amp_sd_n}, 1);
        check("rewake_playing", {31'd0, playing}, 0);
        check_frame("rewake_b1", 0, 1'b0);
        check_frame("rewake_b2", 0, 1'b0);
        check("rewake_playing_b2", {31'd0, playing}, 1);
        check_frame("rewake_b3", 0, 1'b0);
        step(20);
        check("mid_pwm", {31'd0, pwm_out}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_pwm", {31'd0, pwm_out}, 0);
        check("async_amp", {31'd0, amp_sd_n}, 0);
        check("async_playing", {31'd0, playing}, 0);
        step(3);
        @(negedge clk);
        rst_n = 1'b1;

        // Wake sequence again after reset release
        step(255);
        check("rerun_amp_c255", {31'd0, amp_sd_n}, 0);
        step(1);
        check("rerun_amp_c256", {31'd0, amp_sd_n}, 1);
        step(512);
        check("rerun_playing_c768", {31'd0, playing}, 1);
        check_frame("rerun_gap", 0, 1'b0);
        check_frame("rerun_d100", 100, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
